// File: rtl/draw_card_hand_pkg.sv
// draw_card_hand_pkg: shared VGA timing constants, card geometry and stream types
package draw_card_hand_pkg;
    localparam int HOR_TOTAL  = 1344;
    localparam int HOR_ACTIVE = 1024;
    localparam int VER_TOTAL  = 806;
    localparam int VER_ACTIVE = 768;
    localparam int CARD_W     = 48;
    localparam int CARD_H     = 64;
    localparam int CARD_PITCH = 52;
    localparam int MAX_CARDS  = 4;
    localparam logic [11:0] KEY_RGB = 12'hF0F;
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vga_timing_t;
endpackage

// File: rtl/draw_card_hand_timing_delay.sv
// timing_delay: fixed-depth register delay line with async active-low clear
module timing_delay #(
    parameter int W = 26,
    parameter int D = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] pipe [D];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < D; i++) pipe[i] <= '0;
        else begin
            pipe[0] <= din;
            for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end
    assign dout = pipe[D-1];
endmodule

// File: rtl/draw_card_hand.sv
// draw_card_hand: overlays a row of up to four keyed card sprites on a VGA stream, 3-cycle latency
module draw_card_hand #(
    parameter int          CARD_W     = draw_card_hand_pkg::CARD_W,
    parameter int          CARD_H     = draw_card_hand_pkg::CARD_H,
    parameter int          CARD_PITCH = draw_card_hand_pkg::CARD_PITCH,
    parameter logic [11:0] KEY_RGB    = draw_card_hand_pkg::KEY_RGB
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    input  logic [2:0]  num_cards,
    output logic [11:0] rom_addr,
    output logic [1:0]  card_idx,
    input  logic [11:0] rom_rgb,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);
    import draw_card_hand_pkg::*;
    logic [10:0] xs, ys;
    logic [2:0]  ns, n_eff;
    logic [11:0] h12, v12, x12, y12;
    logic        v_in, hit, hit_d;
    logic [1:0]  k_sel;
    logic [5:0]  dx;
    logic [11:0] rgb_d;
    vga_timing_t t_in, t_out;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            xs <= '0;
            ys <= '0;
            ns <= '0;
        end else if (hcount_in == '0 && vcount_in == '0) begin
            xs <= xpos;
            ys <= ypos;
            ns <= num_cards;
        end
    assign n_eff = ns > 3'(MAX_CARDS) ? 3'(MAX_CARDS) : ns;
    // 12-bit math keeps cards that run past 2047 from wrapping onto the left edge
    assign h12  = {1'b0, hcount_in};
    assign v12  = {1'b0, vcount_in};
    assign x12  = {1'b0, xs};
    assign y12  = {1'b0, ys};
    assign v_in = v12 >= y12 && v12 <= y12 + 12'(CARD_H - 1);
    always_comb begin
        hit   = 1'b0;
        k_sel = '0;
        dx    = '0;
        for (int k = MAX_CARDS - 1; k >= 0; k--)
            if (k < int'(n_eff) && v_in && h12 >= x12 + 12'(k * CARD_PITCH) &&
                h12 <= x12 + 12'(k * CARD_PITCH + CARD_W - 1)) begin
                hit   = 1'b1;
                k_sel = 2'(k);
                dx    = 6'(h12 - x12 - 12'(k * CARD_PITCH));
            end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rom_addr <= '0;
            card_idx <= '0;
        end else begin
            rom_addr <= hit ? {6'(v12 - y12), dx} : '0;
            card_idx <= hit ? k_sel : '0;
        end
    // blanking folded into hit here so only one bit needs to travel with the background colour
    timing_delay #(.W(13), .D(2)) u_pix_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({hit && !hblnk_in && !vblnk_in, rgb_in}),
        .dout ({hit_d, rgb_d})
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rgb_out <= '0;
        else        rgb_out <= (hit_d && rom_rgb != KEY_RGB) ? rom_rgb : rgb_d;
    assign t_in = '{hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    timing_delay #(.W($bits(vga_timing_t)), .D(3)) u_timing_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (t_in),
        .dout (t_out)
    );
    assign hcount_out = t_out.hcount;
    assign vcount_out = t_out.vcount;
    assign hsync_out  = t_out.hsync;
    assign vsync_out  = t_out.vsync;
    assign hblnk_out  = t_out.hblnk;
    assign vblnk_out  = t_out.vblnk;
endmodule
